// File: rtl/processador_blocos_pkg.sv
// Shared definitions for the block processor: opcodes, FSM states and the
// stack control encoding.
package processador_blocos_pkg;

    // Opcodes live in instruction bits [7:4]
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_PUSH = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        PUSH   = 3'd2,
        POP_A  = 3'd3,
        POP_B  = 3'd4,
        EXEC   = 3'd5,
        HALT   = 3'd6
    } estado_t;

    typedef enum logic [1:0] {
        PILHA_HOLD     = 2'b00,
        PILHA_PUSH_UC  = 2'b01,
        PILHA_PUSH_ULA = 2'b10,
        PILHA_POP      = 2'b11
    } ctrl_pilha_t;

    // Two-operand ALU instructions pop twice and push the result
    function automatic logic is_op_ula(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/processador_blocos_stack_lifo.sv
// LIFO operand stack. indice counts valid entries; the top is entry indice-1.
// Pushes on a full stack and pops on an empty one are silently dropped.
module stack_lifo
    import processador_blocos_pkg::*;
#(
    parameter  int DATA_W      = 8,
    parameter  int STACK_DEPTH = 8,
    localparam int IW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] din_UC,
    input  logic [DATA_W-1:0] din_ULA,
    input  ctrl_pilha_t       controle_pilha,
    output logic [DATA_W-1:0] dout,
    output logic [IW-1:0]     indice
);

    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [DATA_W-1:0] mem [STACK_DEPTH];
    logic              cheia;
    logic              vazia;

    assign cheia = (indice == IW'(STACK_DEPTH));
    assign vazia = (indice == '0);

    // Top of stack, forced to zero when nothing is stored
    assign dout = vazia ? '0 : mem[AW'(indice - 1'b1)];

    // Storage and occupancy update
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            indice <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= '0;
        end else begin
            case (controle_pilha)
                PILHA_PUSH_UC: if (!cheia) begin
                    mem[AW'(indice)] <= din_UC;
                    indice           <= indice + 1'b1;
                end
                PILHA_PUSH_ULA: if (!cheia) begin
                    mem[AW'(indice)] <= din_ULA;
                    indice           <= indice + 1'b1;
                end
                PILHA_POP: if (!vazia) indice <= indice - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/processador_blocos_top.sv
// Self-running stack processor: FSM sequencer, program ROM, operand
// temporaries and ALU around a LIFO stack.
module processador_blocos_top
    import processador_blocos_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int STACK_DEPTH = 8,
    parameter int ROM_DEPTH   = 16,
    // Word i of the program sits at bits [i*DATA_W +: DATA_W]
    parameter logic [ROM_DEPTH*DATA_W-1:0] ROM_INIT = {
        {(ROM_DEPTH-3){DATA_W'(8'hF0)}},
        DATA_W'(8'h20), DATA_W'(8'h13), DATA_W'(8'h15)
    }
) (
    input logic clock,
    input logic reset
);

    localparam int PCW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int IW  = $clog2(STACK_DEPTH + 1);

    estado_t           estado_atual;
    logic [PCW-1:0]    a_rom;
    logic [DATA_W-1:0] data_mem;
    logic [IW-1:0]     indice;
    ctrl_pilha_t       controle_pilha;
    logic [DATA_W-1:0] resultado;
    logic [DATA_W-1:0] temp1;
    logic [DATA_W-1:0] temp2;
    logic [DATA_W-1:0] topo;
    logic [DATA_W-1:0] din_UC;
    // ALU opcode is latched at decode so resultado stays put once halted
    logic [3:0]        op_ula;
    logic [3:0]        opcode;

    assign opcode = data_mem[7:4];
    assign din_UC = DATA_W'(data_mem[3:0]);

    function automatic logic [PCW-1:0] pc_inc(input logic [PCW-1:0] pc);
        return (pc == PCW'(ROM_DEPTH - 1)) ? '0 : pc + 1'b1;
    endfunction

    stack_lifo #(
        .DATA_W      (DATA_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_pilha (
        .clock          (clock),
        .reset          (reset),
        .din_UC         (din_UC),
        .din_ULA        (resultado),
        .controle_pilha (controle_pilha),
        .dout           (topo),
        .indice         (indice)
    );

    // Sequencer; controle_pilha is registered one state ahead of its use
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_atual   <= FETCH;
            a_rom          <= '0;
            data_mem       <= '0;
            temp1          <= '0;
            temp2          <= '0;
            op_ula         <= OP_ADD;
            controle_pilha <= PILHA_HOLD;
        end else begin
            case (estado_atual)
                FETCH: begin
                    data_mem     <= ROM_INIT[a_rom*DATA_W +: DATA_W];
                    estado_atual <= DECODE;
                end
                DECODE: begin
                    if (opcode == OP_PUSH) begin
                        controle_pilha <= PILHA_PUSH_UC;
                        estado_atual   <= PUSH;
                    end else if (is_op_ula(opcode)) begin
                        op_ula         <= opcode;
                        controle_pilha <= PILHA_POP;
                        estado_atual   <= POP_A;
                    end else if (opcode == OP_HALT) begin
                        estado_atual   <= HALT;
                    end else begin
                        a_rom          <= pc_inc(a_rom);
                        estado_atual   <= FETCH;
                    end
                end
                PUSH: begin
                    controle_pilha <= PILHA_HOLD;
                    a_rom          <= pc_inc(a_rom);
                    estado_atual   <= FETCH;
                end
                POP_A: begin
                    temp1        <= topo;
                    estado_atual <= POP_B;
                end
                POP_B: begin
                    temp2          <= topo;
                    controle_pilha <= PILHA_PUSH_ULA;
                    estado_atual   <= EXEC;
                end
                EXEC: begin
                    controle_pilha <= PILHA_HOLD;
                    a_rom          <= pc_inc(a_rom);
                    estado_atual   <= FETCH;
                end
                HALT: begin
                    controle_pilha <= PILHA_HOLD;
                end
                default: estado_atual <= FETCH;
            endcase
        end
    end

    // ALU: second-popped operand is the left-hand side
    always_comb begin
        resultado = '0;
        case (op_ula)
            OP_ADD:  resultado = temp2 + temp1;
            OP_SUB:  resultado = temp2 - temp1;
            OP_AND:  resultado = temp2 & temp1;
            OP_OR:   resultado = temp2 | temp1;
            OP_XOR:  resultado = temp2 ^ temp1;
            default: resultado = '0;
        endcase
    end

endmodule

// File: tb/tb_processador_blocos_top.sv
// Bench for processador_blocos_top: several programs run side by side, each
// checked against a queue-based interpreter, with randomly timed resets.
module tb_processador_blocos_top;
    import processador_blocos_pkg::*;

    localparam int NP     = 7;
    localparam int BUDGET = 60;

    // 0 default, 1 SUB, 2 SUB wrap, 3 nine pushes, 4 ADD on empty,
    // 5 AND/XOR/OR/NOP/unknown mix, 6 all NOP (PC wrap)
    localparam logic [127:0] PROGS [NP] = '{
        128'hF0F0F0F0_F0F0F0F0_F0F0F0F0_F0201315,
        128'hF0F0F0F0_F0F0F0F0_F0F0F0F0_F0301315,
        128'hF0F0F0F0_F0F0F0F0_F0F0F0F0_F0301513,
        128'hF0F0F0F0_F0F0F011_11111111_11111111,
        128'hF0F0F0F0_F0F0F0F0_F0F0F0F0_F0F0F020,
        128'hF0F0F0F0_F0F0F075_00501160_16401A1C,
        128'h00000000_00000000_00000000_00000000
    };

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [2:0] st_obs  [NP];
    logic [3:0] pc_obs  [NP];
    logic [3:0] ind_obs [NP];
    logic [7:0] top_obs [NP];
    logic [7:0] res_obs [NP];
    logic [7:0] t1_obs  [NP];
    logic [7:0] t2_obs  [NP];
    logic [7:0] dm_obs  [NP];

    always #5 clock = ~clock;

    for (genvar g = 0; g < NP; g++) begin : gen_dut
        processador_blocos_top #(.ROM_INIT(PROGS[g])) dut (
            .clock (clock),
            .reset (reset)
        );
        assign st_obs[g]  = dut.estado_atual;
        assign pc_obs[g]  = dut.a_rom;
        assign ind_obs[g] = dut.indice;
        assign top_obs[g] = dut.topo;
        assign res_obs[g] = dut.resultado;
        assign t1_obs[g]  = dut.temp1;
        assign t2_obs[g]  = dut.temp2;
        assign dm_obs[g]  = dut.data_mem;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction-level interpreter: FETCH+DECODE cost 2 edges, PUSH adds 1,
    // an ALU op adds 3 (two pops and the push of the result).
    task automatic model(input logic [127:0] p, input int budget,
                         output bit halted, output int hcyc, output int pc,
                         output logic [7:0] top, output int ind,
                         output logic [7:0] res, output logic [7:0] t1,
                         output logic [7:0] t2);
        logic [7:0] q[$];
        logic [7:0] w, a, b;
        int cyc;
        halted = 0; hcyc = 0; pc = 0; res = 0; t1 = 0; t2 = 0; cyc = 0;
        for (int step = 0; step < 200; step++) begin
            w = p[pc*8 +: 8];
            if (cyc + 2 > budget) break;
            if (w[7:4] == 4'hF) begin
                halted = 1; hcyc = cyc + 2;
                break;
            end else if (w[7:4] == 4'h1) begin
                if (cyc + 3 > budget) break;
                if (q.size() < 8) q.push_back({4'h0, w[3:0]});
                cyc += 3;
            end else if (w[7:4] >= 4'h2 && w[7:4] <= 4'h6) begin
                if (cyc + 5 > budget) break;
                if (q.size() > 0) a = q.pop_back(); else a = 0;
                if (q.size() > 0) b = q.pop_back(); else b = 0;
                t1 = a; t2 = b;
                case (w[7:4])
                    4'h2: res = b + a;
                    4'h3: res = b - a;
                    4'h4: res = b & a;
                    4'h5: res = b | a;
                    default: res = b ^ a;
                endcase
                q.push_back(res);
                cyc += 5;
            end else begin
                cyc += 2;
            end
            pc = (pc + 1) % 16;
        end
        ind = q.size();
        top = (ind > 0) ? q[ind-1] : 8'h00;
    endtask

    task automatic check_reset(input string ph);
        for (int g = 0; g < NP; g++) begin
            chk($sformatf("%s p%0d rst_state", ph, g), 32'(st_obs[g]), 32'(FETCH));
            chk($sformatf("%s p%0d rst_pc", ph, g), 32'(pc_obs[g]), 0);
            chk($sformatf("%s p%0d rst_indice", ph, g), 32'(ind_obs[g]), 0);
            chk($sformatf("%s p%0d rst_top", ph, g), 32'(top_obs[g]), 0);
            chk($sformatf("%s p%0d rst_dmem", ph, g), 32'(dm_obs[g]), 0);
            chk($sformatf("%s p%0d rst_temps", ph, g), {16'h0, t2_obs[g], t1_obs[g]}, 0);
        end
    endtask

    // Release reset, run BUDGET edges, then compare every instance with the model
    task automatic run_prog(input string ph);
        int hc [NP];
        bit seen [NP];
        bit m_halt;
        int m_hc, m_pc, m_ind;
        logic [7:0] m_top, m_res, m_t1, m_t2;
        for (int g = 0; g < NP; g++) begin seen[g] = 0; hc[g] = 0; end
        @(negedge clock);
        reset = 1'b0;
        for (int c = 1; c <= BUDGET; c++) begin
            @(posedge clock);
            #1;
            for (int g = 0; g < NP; g++)
                if (!seen[g] && st_obs[g] == 3'(HALT)) begin seen[g] = 1; hc[g] = c; end
        end
        for (int g = 0; g < NP; g++) begin
            model(PROGS[g], BUDGET, m_halt, m_hc, m_pc, m_top, m_ind, m_res, m_t1, m_t2);
            chk($sformatf("%s p%0d halted", ph, g), 32'(seen[g]), 32'(m_halt));
            if (m_halt) chk($sformatf("%s p%0d halt_cycle", ph, g), hc[g], m_hc);
            chk($sformatf("%s p%0d pc", ph, g), 32'(pc_obs[g]), m_pc);
            chk($sformatf("%s p%0d indice", ph, g), 32'(ind_obs[g]), m_ind);
            chk($sformatf("%s p%0d top", ph, g), 32'(top_obs[g]), 32'(m_top));
            chk($sformatf("%s p%0d resultado", ph, g), 32'(res_obs[g]), 32'(m_res));
            chk($sformatf("%s p%0d temp1", ph, g), 32'(t1_obs[g]), 32'(m_t1));
            chk($sformatf("%s p%0d temp2", ph, g), 32'(t2_obs[g]), 32'(m_t2));
        end
    endtask

    initial begin
        int k;
        bit found;

        #3;
        check_reset("por");
        run_prog("run0");

        // Randomly timed asynchronous resets in the middle of execution
        for (int r = 0; r < 3; r++) begin
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            k = $urandom_range(1, 30);
            repeat (k) @(posedge clock);
            #($urandom_range(1, 8));
            reset = 1'b1;
            #1;
            check_reset($sformatf("rnd%0d", r));
            run_prog($sformatf("rerun%0d", r));
        end

        // Reset while the default program sits in POP_B
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        found = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(posedge clock);
            #1;
            if (st_obs[0] == 3'(POP_B)) found = 1;
        end
        chk("popb_reached", 32'(found), 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset("popb");
        @(posedge clock);
        #1;
        chk("popb hold_state", 32'(st_obs[0]), 32'(FETCH));
        chk("popb hold_indice", 32'(ind_obs[0]), 0);
        run_prog("popb_rerun");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
